// File: rtl/cpu_defs.sv
// Shared CPU definitions: MULT/DIV op codes and sequencer states.
// The control unit uses the same op constants.
package cpu_defs;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_MD_IDLE = 2'd0,
        ST_MD_MULT = 2'd1,
        ST_MD_DIV  = 2'd2,
        ST_MD_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Brings in the next dividend bit and trial-subtracts the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // Shift in the next dividend bit; keep the difference only if it stays non-negative.
    always_comb begin
        shifted   = {rem, quotient[WIDTH-1]};
        fits      = (shifted >= {1'b0, divisor});
        rem_next  = fits ? WIDTH'(shifted - {1'b0, divisor})
                         : shifted[WIDTH-1:0];
        quot_next = {quotient[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine with HI/LO result registers.
// Works on operand magnitudes, then fixes the signs in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import cpu_defs::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t          state;
    md_state_t          state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               op_q;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_pend;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     m_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   d_rem_next;
    logic [WIDTH-1:0]   d_quo_next;

    // Operand magnitudes; an unsigned W-bit value still represents 2^(W-1).
    always_comb begin
        accept    = start && !busy && (state == ST_MD_IDLE);
        last_iter = (cnt == CW'(WIDTH - 1));
        mag_a     = src_a[WIDTH-1] ? -src_a : src_a;
        mag_b     = src_b[WIDTH-1] ? -src_b : src_b;
        m_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {m_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:1]};
    end

    // Division keeps the remainder in acc's upper half, the quotient in the lower.
    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .quotient (acc[WIDTH-1:0]),
        .divisor  (opnd),
        .rem_next (d_rem_next),
        .quot_next(d_quo_next)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_MD_IDLE;
        else        state <= state_next;
    end

    // Next-state: divide by zero stays idle and reports on the next edge.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_MD_IDLE: begin
                if (accept) begin
                    if (op == MD_OP_MULT)  state_next = ST_MD_MULT;
                    else if (src_b != '0)  state_next = ST_MD_DIV;
                end
            end
            ST_MD_MULT,
            ST_MD_DIV: if (last_iter) state_next = ST_MD_FIX;
            ST_MD_FIX: state_next = ST_MD_IDLE;
            default:   state_next = ST_MD_IDLE;
        endcase
    end

    // Datapath, counter, handshake and HI/LO result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                ST_MD_IDLE: begin
                    if (dz_pend) begin
                        dz_pend  <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else if (accept) begin
                        busy    <= 1'b1;
                        cnt     <= '0;
                        op_q    <= op;
                        neg_res <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                        neg_rem <= src_a[WIDTH-1];
                        dz_pend <= (op == MD_OP_DIV) && (src_b == '0);
                        if (op == MD_OP_MULT) begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end
                    end
                end
                ST_MD_MULT: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                end
                ST_MD_DIV: begin
                    acc <= {d_rem_next, d_quo_next};
                    cnt <= cnt + CW'(1);
                end
                ST_MD_FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (op_q == MD_OP_MULT) begin
                        {hi, lo} <= neg_res ? -acc : acc;
                    end else begin
                        lo <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= neg_rem ? -acc[2*WIDTH-1:WIDTH]
                                      : acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
